// File: rtl/audio_pkg.sv
// Shared audio-path types: sample width, slot limit and the I2S receiver state encoding.
package audio_pkg;

  localparam int SAMPLE_W = 16;
  localparam int SLOT_MAX = 32;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  typedef enum logic [1:0] {
    RX_SYNC  = 2'd0,
    RX_LEFT  = 2'd1,
    RX_RIGHT = 2'd2
  } i2s_rx_state_t;

endpackage

// File: rtl/i2s_slot_shifter.sv
// Per-slot MSB-first bit collector: counts slot bits, keeps the first SAMPLE_W, zero-pads short slots.
// word_o already includes the bit presented this edge so the FSM can capture it on the closing edge.
module i2s_slot_shifter #(
  parameter int SAMPLE_W = 16,
  parameter int SLOT_MAX = 32
) (
  input  logic                sclk_i,
  input  logic                rst_n_i,
  input  logic                en_i,
  input  logic                clr_i,
  input  logic                bit_i,
  output logic [SAMPLE_W-1:0] word_o,
  output logic                short_o,
  output logic                long_o
);

  localparam int CNT_W = $clog2(SLOT_MAX + 2);
  localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(SLOT_MAX + 1);

  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [SAMPLE_W-1:0] shreg_q, shreg_d;
  logic [SAMPLE_W-1:0] bit_mask;
  logic [SAMPLE_W-1:0] word;

  // Mask walks down from the MSB and shifts out to zero once SAMPLE_W bits are held.
  always_comb begin
    bit_mask = {1'b1, {(SAMPLE_W-1){1'b0}}} >> cnt_q;
    word     = shreg_q;
    if (en_i && bit_i) begin
      word = shreg_q | bit_mask;
    end
  end

  always_comb begin
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    if (clr_i) begin
      cnt_d   = '0;
      shreg_d = '0;
    end else if (en_i) begin
      shreg_d = word;
      if (cnt_q != CNT_SAT) begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge sclk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q   <= '0;
      shreg_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
    end
  end

  assign word_o  = word;
  // Counting the current bit, the slot holds cnt_q+1 bits.
  assign short_o = en_i && (cnt_q < CNT_W'(SAMPLE_W - 1));
  assign long_o  = en_i && (cnt_q >= CNT_W'(SLOT_MAX));

endmodule

// File: rtl/i2s_rx_deserializer.sv
// Philips I2S receiver: frame-locks on ws, emits one registered {left,right} pair per frame
// with a single-cycle valid strobe; short or overlong slots raise a sticky framing fault.
module i2s_rx_deserializer #(
  parameter int SAMPLE_W = audio_pkg::SAMPLE_W,
  parameter int SLOT_MAX = audio_pkg::SLOT_MAX
) (
  input  logic                sclk_i,
  input  logic                rst_n_i,
  input  logic                ws_i,
  input  logic                sdata_i,
  output logic [SAMPLE_W-1:0] left_o,
  output logic [SAMPLE_W-1:0] right_o,
  output logic                valid_o,
  output logic                locked_o,
  output logic                frame_err_o
);

  import audio_pkg::*;

  i2s_rx_state_t state_q, state_d;

  logic                ws_q;
  logic                ws_trans;
  logic                ws_fall;
  logic                locked;
  logic                shift_clr;
  logic                cap_left;
  logic                cap_right;
  logic                set_err;
  logic [SAMPLE_W-1:0] slot_word;
  logic                slot_short;
  logic                slot_long;
  logic [SAMPLE_W-1:0] left_hold_q;
  logic [SAMPLE_W-1:0] left_q;
  logic [SAMPLE_W-1:0] right_q;
  logic                valid_q;
  logic                err_q;

  assign ws_trans = ws_i ^ ws_q;
  assign ws_fall  = ws_q & ~ws_i;

  i2s_slot_shifter #(
    .SAMPLE_W (SAMPLE_W),
    .SLOT_MAX (SLOT_MAX)
  ) u_shifter (
    .sclk_i  (sclk_i),
    .rst_n_i (rst_n_i),
    .en_i    (locked),
    .clr_i   (shift_clr),
    .bit_i   (sdata_i),
    .word_o  (slot_word),
    .short_o (slot_short),
    .long_o  (slot_long)
  );

  always_ff @(posedge sclk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= RX_SYNC;
      ws_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ws_q    <= ws_i;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RX_SYNC: begin
        if (ws_fall) begin
          state_d = RX_LEFT;
        end
      end
      RX_LEFT: begin
        if (ws_trans) begin
          state_d = RX_RIGHT;
        end else if (slot_long) begin
          state_d = RX_SYNC;
        end
      end
      RX_RIGHT: begin
        if (ws_trans) begin
          state_d = RX_LEFT;
        end else if (slot_long) begin
          state_d = RX_SYNC;
        end
      end
      default: state_d = RX_SYNC;
    endcase
  end

  // While unlocked the shifter is held clear so the first locked slot starts from bit 0.
  always_comb begin
    locked    = (state_q == RX_LEFT) || (state_q == RX_RIGHT);
    shift_clr = !locked || ws_trans || slot_long;
    cap_left  = (state_q == RX_LEFT)  && ws_trans;
    cap_right = (state_q == RX_RIGHT) && ws_trans;
    set_err   = locked && ((ws_trans && slot_short) || (!ws_trans && slot_long));
  end

  always_ff @(posedge sclk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      left_hold_q <= '0;
      left_q      <= '0;
      right_q     <= '0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      valid_q <= cap_right;
      if (cap_left) begin
        left_hold_q <= slot_word;
      end
      if (cap_right) begin
        left_q  <= left_hold_q;
        right_q <= slot_word;
      end
      if (set_err) begin
        err_q <= 1'b1;
      end
    end
  end

  assign left_o      = left_q;
  assign right_o     = right_q;
  assign valid_o     = valid_q;
  assign locked_o    = locked;
  assign frame_err_o = err_q;

endmodule

// File: tb/tb_i2s_rx_deserializer.sv
// Bench for the I2S receiver: table of frames driven through a bit-accurate Philips serializer,
// with expected pairs queued per frame and popped whenever valid_o is seen.
module tb_i2s_rx_deserializer;

  logic        sclk_i;
  logic        rst_n_i;
  logic        ws_i;
  logic        sdata_i;
  logic [15:0] left_o;
  logic [15:0] right_o;
  logic        valid_o;
  logic        locked_o;
  logic        frame_err_o;

  i2s_rx_deserializer #(
    .SAMPLE_W (16),
    .SLOT_MAX (32)
  ) dut (
    .sclk_i      (sclk_i),
    .rst_n_i     (rst_n_i),
    .ws_i        (ws_i),
    .sdata_i     (sdata_i),
    .left_o      (left_o),
    .right_o     (right_o),
    .valid_o     (valid_o),
    .locked_o    (locked_o),
    .frame_err_o (frame_err_o)
  );

  initial sclk_i = 1'b0;
  always #5 sclk_i = ~sclk_i;

  typedef struct {
    int          n;
    logic [31:0] l;
    logic [31:0] r;
    bit          vld;
    logic [15:0] el;
    logic [15:0] er;
    bit          lock;
    bit          err;
  } vec_t;

  typedef struct packed {
    logic [15:0] l;
    logic [15:0] r;
  } pair_t;

  vec_t  vecs[8];
  pair_t sb_q[$];
  int    valid_edges[$];
  int    edge_cnt;
  int    checks;
  int    errors;
  logic  prev_bit;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Transmitter view: ws changes with the slot, data lags ws by one bit clock.
  task automatic send_word(input logic w, input logic [31:0] val, input int n);
    for (int k = n - 1; k >= 0; k--) begin
      @(negedge sclk_i);
      ws_i     = w;
      sdata_i  = prev_bit;
      prev_bit = val[k];
      @(posedge sclk_i);
    end
    #1;
  endtask

  task automatic run_vec(input int i);
    if (vecs[i].vld) begin
      sb_q.push_back('{l: vecs[i].el, r: vecs[i].er});
    end
    send_word(1'b0, vecs[i].l, vecs[i].n);
    send_word(1'b1, vecs[i].r, vecs[i].n);
    chk($sformatf("v%0d_locked", i), {31'd0, locked_o}, {31'd0, vecs[i].lock});
    chk($sformatf("v%0d_frame_err", i), {31'd0, frame_err_o}, {31'd0, vecs[i].err});
  endtask

  always @(posedge sclk_i) edge_cnt <= edge_cnt + 1;

  always @(negedge sclk_i) begin
    if (valid_o === 1'b1) begin
      valid_edges.push_back(edge_cnt);
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid actual=1 required=0 left=%h right=%h", left_o, right_o);
      end else begin
        pair_t exp_p;
        exp_p = sb_q.pop_front();
        chk("pair_left", {16'd0, left_o}, {16'd0, exp_p.l});
        chk("pair_right", {16'd0, right_o}, {16'd0, exp_p.r});
      end
    end
  end

  initial begin
    checks   = 0;
    errors   = 0;
    edge_cnt = 0;
    prev_bit = 1'b0;
    rst_n_i  = 1'b0;
    ws_i     = 1'b0;
    sdata_i  = 1'b0;

    vecs[0] = '{16, 32'h0000_DEAD, 32'h0000_BEEF, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0};
    vecs[1] = '{16, 32'h0000_DEAD, 32'h0000_BEEF, 1'b1, 16'hDEAD, 16'hBEEF, 1'b1, 1'b0};
    vecs[2] = '{16, 32'h0000_BEEF, 32'h0000_DEAD, 1'b1, 16'hBEEF, 16'hDEAD, 1'b1, 1'b0};
    vecs[3] = '{32, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 16'h1234, 16'h9ABC, 1'b1, 1'b0};
    vecs[4] = '{16, 32'h0000_1111, 32'h0000_2222, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1};
    vecs[5] = '{12, 32'h0000_0ABC, 32'h0000_0123, 1'b1, 16'hABC0, 16'h1230, 1'b1, 1'b1};
    vecs[6] = '{16, 32'h0000_8001, 32'h0000_7FFE, 1'b1, 16'h8001, 16'h7FFE, 1'b1, 1'b1};
    vecs[7] = '{16, 32'h0000_5A5A, 32'h0000_A5A5, 1'b1, 16'h5A5A, 16'hA5A5, 1'b1, 1'b0};

    #20;
    chk("rst_left", {16'd0, left_o}, 32'd0);
    chk("rst_right", {16'd0, right_o}, 32'd0);
    chk("rst_valid", {31'd0, valid_o}, 32'd0);
    chk("rst_locked", {31'd0, locked_o}, 32'd0);
    chk("rst_frame_err", {31'd0, frame_err_o}, 32'd0);
    #20;
    rst_n_i = 1'b1;

    for (int i = 0; i <= 3; i++) begin
      run_vec(i);
    end
    if (valid_edges.size() >= 2) begin
      chk("valid_spacing", valid_edges[1] - valid_edges[0], 32);
    end else begin
      chk("valid_count", valid_edges.size(), 2);
    end

    // ws stuck low: first edge closes frame 3, then 33 left-slot bits overflow the slot.
    for (int k = 1; k <= 40; k++) begin
      send_word(1'b0, 32'($urandom_range(0, 1)), 1);
      if (k == 33) begin
        chk("ovf_locked_bit32", {31'd0, locked_o}, 32'd1);
        chk("ovf_err_bit32", {31'd0, frame_err_o}, 32'd0);
      end
      if (k == 34) begin
        chk("ovf_locked_bit33", {31'd0, locked_o}, 32'd0);
        chk("ovf_err_bit33", {31'd0, frame_err_o}, 32'd1);
      end
    end
    chk("ovf_locked_end", {31'd0, locked_o}, 32'd0);

    for (int i = 4; i <= 6; i++) begin
      run_vec(i);
    end

    // Reset in the middle of a right slot: partial frame must vanish.
    send_word(1'b0, 32'h0000_1357, 16);
    send_word(1'b1, 32'h0000_0024, 8);
    chk("pre_rst_left", {16'd0, left_o}, 32'h0000_8001);
    #2;
    rst_n_i = 1'b0;
    #1;
    chk("mid_rst_left", {16'd0, left_o}, 32'd0);
    chk("mid_rst_right", {16'd0, right_o}, 32'd0);
    chk("mid_rst_valid", {31'd0, valid_o}, 32'd0);
    chk("mid_rst_locked", {31'd0, locked_o}, 32'd0);
    chk("mid_rst_frame_err", {31'd0, frame_err_o}, 32'd0);
    @(negedge sclk_i);
    @(negedge sclk_i);
    rst_n_i = 1'b1;

    run_vec(7);
    send_word(1'b0, 32'd0, 1);
    repeat (4) @(negedge sclk_i);
    chk("pending_pairs", sb_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
